mem_port_arbiter: RTL and testbench

- Shares the single unified instruction/data memory port between two requesters.
- Requester 0 is the multicycle core (fetch, load and store traffic).
- Requester 1 is the program loader/debug port, which writes images and peeks memory while the core runs or stalls.
- Issues one transaction at a time, with round-robin fairness, fixed-latency memory timing, address range/alignment checking and a per-requester completion pulse.

---
 rtl/mem_arb_pkg.sv | 12 +
 rtl/mem_port_arbiter_rr_pick2.sv | 12 +
 rtl/mem_port_arbiter.sv | 109 ++++++++++
 tb/tb_mem_port_arbiter.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory port arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    WAIT   = 2'b10,
    DONE   = 2'b11
  } state_t;
  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_LOAD = 1'b1;
  localparam int WSTRB_W = 4;
endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin selector, a tie goes to the requester that was not granted last
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       winner
);
  assign valid  = |req;
  assign winner = (&req) ? ~last : req[REQ_LOAD];
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between the core and the loader, one transaction at a time
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int MEM_BYTES   = 4096,
  parameter int MEM_LATENCY = 1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               r0_req,
  input  logic               r0_we,
  input  logic [ADDR_W-1:0]  r0_addr,
  input  logic [31:0]        r0_wdata,
  input  logic [WSTRB_W-1:0] r0_wstrb,
  output logic               r0_gnt,
  output logic               r0_done,
  output logic               r0_err,
  output logic [31:0]        r0_rdata,
  input  logic               r1_req,
  input  logic               r1_we,
  input  logic [ADDR_W-1:0]  r1_addr,
  input  logic [31:0]        r1_wdata,
  input  logic [WSTRB_W-1:0] r1_wstrb,
  output logic               r1_gnt,
  output logic               r1_done,
  output logic               r1_err,
  output logic [31:0]        r1_rdata,
  output logic               mem_en,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [31:0]        mem_wdata,
  output logic [WSTRB_W-1:0] mem_wstrb,
  input  logic [31:0]        mem_rdata,
  output logic               busy
);
  localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);
  state_t state, state_nx;
  logic last_grant, sel, we_q, pick_valid, pick_winner, addr_ok, acc, fin;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0] wdata_q, rd_show;
  logic [WSTRB_W-1:0] wstrb_q;
  logic [3:0] cnt;
  logic [1:0][31:0] rd_q;
  logic [1:0] er_q;
  rr_pick2 u_pick (
    .req    ({r1_req, r0_req}),
    .last   (last_grant),
    .valid  (pick_valid),
    .winner (pick_winner)
  );
  assign addr_ok = (addr_q < ADDR_W'(MEM_BYTES)) && (addr_q[1:0] == 2'b00);
  assign acc     = state == ACCESS;
  assign fin     = state == DONE;
  // mem_rdata is valid in the DONE cycle itself, so show it directly and keep a copy afterwards
  assign rd_show = (addr_ok && !we_q) ? mem_rdata : '0;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = pick_valid ? ACCESS : IDLE;
      ACCESS:  state_nx = (addr_ok && MEM_LATENCY > 1) ? WAIT : DONE;
      WAIT:    state_nx = (cnt == 4'd1) ? DONE : WAIT;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      last_grant <= REQ_LOAD;
      sel        <= REQ_CORE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      cnt        <= '0;
      rd_q       <= '0;
      er_q       <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && pick_valid) begin
        sel        <= pick_winner;
        last_grant <= pick_winner;
        we_q       <= pick_winner ? r1_we : r0_we;
        addr_q     <= pick_winner ? r1_addr : r0_addr;
        wdata_q    <= pick_winner ? r1_wdata : r0_wdata;
        wstrb_q    <= pick_winner ? r1_wstrb : r0_wstrb;
      end
      cnt <= acc ? CNT_LOAD : (state == WAIT) ? cnt - 4'd1 : cnt;
      if (fin) begin
        rd_q[sel] <= rd_show;
        er_q[sel] <= !addr_ok;
      end
    end
  end
  assign busy      = state != IDLE;
  assign mem_en    = acc && addr_ok;
  assign mem_we    = mem_en && we_q;
  assign mem_addr  = mem_en ? addr_q : '0;
  assign mem_wdata = mem_en ? wdata_q : '0;
  assign mem_wstrb = mem_en ? wstrb_q : '0;
  assign r0_gnt    = acc && sel == REQ_CORE;
  assign r1_gnt    = acc && sel == REQ_LOAD;
  assign r0_done   = fin && sel == REQ_CORE;
  assign r1_done   = fin && sel == REQ_LOAD;
  assign r0_err    = r0_done ? !addr_ok : er_q[0];
  assign r1_err    = r1_done ? !addr_ok : er_q[1];
  assign r0_rdata  = r0_done ? rd_show : rd_q[0];
  assign r1_rdata  = r1_done ? rd_show : rd_q[1];
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized check of three latency variants against a transaction-timeline model
module tb_mem_port_arbiter;
  logic clk = 1'b0, resetn = 1'b0;
  logic r0_req = 1'b0, r0_we = 1'b0, r1_req = 1'b0, r1_we = 1'b0;
  logic [31:0] r0_addr = '0, r0_wdata = '0, r1_addr = '0, r1_wdata = '0, mem_rdata = '0;
  logic [3:0] r0_wstrb = '0, r1_wstrb = '0;
  bit started = 1'b0;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  function automatic logic [31:0] pick_addr();
    logic [31:0] a;
    a = 32'($urandom_range(1023)) << 2;
    case ($urandom_range(7))
      0: a = 32'h1000;
      1: a = $urandom | 32'h1000;
      2: a = a + 32'($urandom_range(3, 1));
      default: ;
    endcase
    return a;
  endfunction
  for (genvar g = 0; g < 3; g++) begin : u
    localparam int L = (g == 0) ? 1 : (g == 1) ? 3 : 4;
    logic gnt0, gnt1, done0, done1, err0, err1, busy, men, mwe;
    logic [31:0] rd0, rd1, maddr, mwd;
    logic [3:0] mws;
    mem_port_arbiter #(.ADDR_W(32), .MEM_BYTES(4096), .MEM_LATENCY(L)) dut (
      .clk(clk), .resetn(resetn),
      .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_wstrb(r0_wstrb),
      .r0_gnt(gnt0), .r0_done(done0), .r0_err(err0), .r0_rdata(rd0),
      .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_wstrb(r1_wstrb),
      .r1_gnt(gnt1), .r1_done(done1), .r1_err(err1), .r1_rdata(rd1),
      .mem_en(men), .mem_we(mwe), .mem_addr(maddr), .mem_wdata(mwd), .mem_wstrb(mws),
      .mem_rdata(mem_rdata), .busy(busy)
    );
    // a transaction accepted at edge E occupies cycles E+1 .. E+d, where cycle E+1 is the grant cycle
    bit m_busy, m_sel, m_we, m_ok, m_last;
    int k, d;
    logic [31:0] m_addr, m_wd, m_rd[2];
    logic [3:0] m_ws;
    bit m_er[2];
    bit acc, fin;
    logic [31:0] shown;
    initial forever begin
      @(posedge clk);
      if (!resetn) begin
        m_busy = 0; m_last = 1; m_rd[0] = 0; m_rd[1] = 0; m_er[0] = 0; m_er[1] = 0;
      end else if (m_busy) begin
        if (k == d) begin
          m_rd[m_sel] = (m_ok && !m_we) ? mem_rdata : 32'h0;
          m_er[m_sel] = !m_ok;
          m_busy = 0;
        end else k++;
      end else if (r0_req || r1_req) begin
        m_sel  = (r0_req && r1_req) ? !m_last : r1_req;
        m_last = m_sel;
        m_we   = m_sel ? r1_we : r0_we;
        m_addr = m_sel ? r1_addr : r0_addr;
        m_wd   = m_sel ? r1_wdata : r0_wdata;
        m_ws   = m_sel ? r1_wstrb : r0_wstrb;
        m_ok   = m_addr < 4096 && m_addr % 4 == 0;
        d      = m_ok ? L + 1 : 2;
        k      = 1;
        m_busy = 1;
      end
    end
    initial forever begin
      @(negedge clk);
      if (started) begin
        acc   = m_busy && k == 1;
        fin   = m_busy && k == d;
        shown = (m_ok && !m_we) ? mem_rdata : 32'h0;
        chk($sformatf("L%0d busy", L), busy, m_busy);
        chk($sformatf("L%0d gnt0", L), gnt0, acc && !m_sel);
        chk($sformatf("L%0d gnt1", L), gnt1, acc && m_sel);
        chk($sformatf("L%0d done0", L), done0, fin && !m_sel);
        chk($sformatf("L%0d done1", L), done1, fin && m_sel);
        chk($sformatf("L%0d err0", L), err0, (fin && !m_sel) ? !m_ok : m_er[0]);
        chk($sformatf("L%0d err1", L), err1, (fin && m_sel) ? !m_ok : m_er[1]);
        chk($sformatf("L%0d rdata0", L), rd0, (fin && !m_sel) ? shown : m_rd[0]);
        chk($sformatf("L%0d rdata1", L), rd1, (fin && m_sel) ? shown : m_rd[1]);
        chk($sformatf("L%0d mem_en", L), men, acc && m_ok);
        chk($sformatf("L%0d mem_we", L), mwe, acc && m_ok && m_we);
        chk($sformatf("L%0d mem_addr", L), maddr, (acc && m_ok) ? m_addr : 32'h0);
        chk($sformatf("L%0d mem_wdata", L), mwd, (acc && m_ok) ? m_wd : 32'h0);
        chk($sformatf("L%0d mem_wstrb", L), mws, (acc && m_ok) ? m_ws : 4'h0);
      end
    end
  end
  initial begin
    @(posedge clk);
    #1;
    started = 1'b1;
    step(2);
    resetn = 1'b1;
    r0_req = 1; r0_addr = 32'h10; mem_rdata = 32'hDEADBEEF;
    step(1);
    r0_req = 0; r0_addr = 32'h40;
    step(8);
    r1_req = 1; r1_we = 1; r1_addr = 32'h20; r1_wdata = 32'h12345678; r1_wstrb = 4'b0011;
    step(1);
    r1_req = 0; r1_addr = $urandom;
    step(8);
    r0_addr = 32'h100; r1_addr = 32'h104; r1_we = 0; mem_rdata = 32'hA5A5_0F0F;
    r0_req = 1; r1_req = 1;
    step(24);
    r0_req = 0; r1_req = 0;
    step(8);
    r0_addr = 32'h1002; r0_req = 1;
    step(1);
    r0_req = 0;
    step(6);
    r1_addr = 32'h1000; r1_req = 1;
    step(1);
    r1_req = 0;
    step(6);
    r0_addr = 32'h8; r0_req = 1;
    step(1);
    r0_req = 0;
    step(2);
    resetn = 0;
    step(1);
    resetn = 1; r1_req = 1; r1_addr = 32'hC;
    step(1);
    r1_req = 0;
    step(8);
    for (int i = 0; i < 2500; i++) begin
      resetn    = $urandom_range(199) != 0;
      r0_req    = 1'($urandom_range(1));
      r1_req    = 1'($urandom_range(1));
      r0_we     = 1'($urandom_range(1));
      r1_we     = 1'($urandom_range(1));
      r0_addr   = pick_addr();
      r1_addr   = pick_addr();
      r0_wdata  = $urandom;
      r1_wdata  = $urandom;
      r0_wstrb  = 4'($urandom);
      r1_wstrb  = 4'($urandom);
      mem_rdata = $urandom;
      step(1);
    end
    resetn = 1; r0_req = 0; r1_req = 0;
    step(10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
